// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: start, 8 data bits MSB-first, parity, stop.
// Presents the byte with a one-cycle completion strobe and parity/framing status.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 14,
  parameter int SAMPLE_AT    = 6
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_type,
  output logic [7:0] rx_msg,
  output logic       rx_complete,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_AT);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sr;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    sync_vld;
  logic          ptype_q;
  logic          p_q;
  logic          stop_q;
  logic          fin;

  logic start_edge;
  logic sample;
  logic wrap;

  assign start_edge = rx_prev & ~rx_s;
  assign sample     = (cnt == CNT_SAMPLE);
  assign wrap       = (cnt == CNT_LAST);

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sr          <= '0;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b0;
      sync_vld    <= 2'b00;
      ptype_q     <= 1'b0;
      p_q         <= 1'b0;
      stop_q      <= 1'b0;
      fin         <= 1'b0;
      rx_msg      <= 8'h00;
      rx_complete <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      sync_vld    <= {sync_vld[0], 1'b1};
      // Hold rx_prev low until rx_s carries a real line sample, so a line
      // held low through reset never looks like a fresh start edge.
      rx_prev     <= sync_vld[1] ? rx_s : 1'b0;
      rx_complete <= 1'b0;
      cnt         <= wrap ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_edge) state <= START;
        end
        START: begin
          if (sample && rx_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            if (sample) ptype_q <= parity_type;
            if (wrap) begin
              state <= DATA;
              idx   <= '0;
            end
          end
        end
        DATA: begin
          if (sample) sr <= {sr[6:0], rx_s};
          if (wrap) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= PARITY;
          end
        end
        PARITY: begin
          if (sample) p_q <= rx_s;
          if (wrap) state <= STOP;
        end
        STOP: begin
          // Results land one edge after the stop sample; leaving mid-bit
          // lets the next start edge be caught after minimal idle time.
          if (fin) begin
            rx_msg      <= sr;
            parity_err  <= p_q ^ (^sr) ^ ptype_q;
            frame_err   <= ~stop_q;
            rx_complete <= 1'b1;
            fin         <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
          end else if (sample) begin
            stop_q <= rx_s;
            fin    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with `uart_tx` on the same 3.125 MHz domain. It deserialises the 11-bit frame `uart_tx` produces: start, 8 data bits MSB-first on the line, parity, stop, at 14 clocks per bit. It presents the recovered byte with a one-cycle completion strobe and parity and framing status. It sits directly downstream of `uart_tx` and is used in loopback with it.

## Interface
- `CLKS_PER_BIT`, 14, clocks per bit period; must be ≥ 4.
- `SAMPLE_AT`, 6, count value within a bit at which the line is sampled; must be < `CLKS_PER_BIT`.

- `clk_3125`  in  1  3.125 MHz clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line; idles high; asynchronous to `clk_3125`.
- `parity_type`  in  1  0 = even, 1 = odd; same encoding as `uart_tx`.
- `rx_msg`  out  8  last received byte, in the same bit order as `uart_tx.data`: the first data bit on the line goes to `rx_msg[7]`.
- `rx_complete`  out  1  one-cycle strobe; `rx_msg` and the error flags are valid from this cycle.
- `parity_err`  out  1  received parity ≠ expected parity; held until the next `rx_complete`.
- `frame_err`  out  1  stop bit sampled low; held until the next `rx_complete`.

## Operation
- **Input synchronisation:** `rx` passes through 2 flops, giving `rx_s`. Both flops reset to 1.
- **Edge detector:** register `rx_prev` holds the previous `rx_s` and resets to 0. A start edge is `rx_prev==1 && rx_s==0`. A line held low through reset therefore starts nothing until it has gone high.
- **Bit counter:** `cnt` counts 0..`CLKS_PER_BIT`-1 and wraps.
- **Bit index:** `idx` counts 0..7.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** on a start edge, go to START with `cnt`=0.
- **START:** at `cnt==SAMPLE_AT`:
  - if `rx_s`==1, it is a false start: return to IDLE, with no outputs changed.
  - otherwise, latch `parity_type` into `ptype_q` and continue.
  - at `cnt` wrap, go to DATA with `idx`=0.
- **DATA:** at `cnt==SAMPLE_AT`, shift `rx_s` into the shift register `sr` with `sr <= {sr[6:0], rx_s}`. At wrap, increment `idx`. After the wrap at `idx`==7, go to PARITY.
- **PARITY:** at `cnt==SAMPLE_AT`, latch `p_q <= rx_s`. At wrap, go to STOP.
- **STOP:** at `cnt==SAMPLE_AT`, on the next edge:
  - `rx_msg <= sr`
  - `parity_err <= p_q ^ (^sr) ^ ptype_q`
  - `frame_err <= ~rx_s`
  - `rx_complete <= 1`
  - state <= IDLE
- Leaving mid-stop-bit lets the receiver catch a start edge from the next frame with as little as 1 idle cycle between frames.
- **Framing error:** a frame with a bad stop bit still produces `rx_complete` and updates `rx_msg`, with `frame_err`=1.
- **Back-to-back start:** if the line is low on re-entry to IDLE (a stop bit that is too short), no start edge exists, so the receiver stays in IDLE until the line has gone high and then low again.
- **`parity_type` during a frame:** changes are ignored; only the value latched in START is used.
- **Reset mid-frame:** on the next edge:
  - state = IDLE, `cnt` = `idx` = 0, `sr` = 0
  - all outputs = 0, synchroniser flops = 1
  - the partial frame is discarded with no strobe.

## Timing
- **Reset values:** `rx_msg`=8'h00, `rx_complete`=0, `parity_err`=0, `frame_err`=0.
- **Reference edge:** S is the clock edge at which the edge detector first sees `rx_s`=0 with `rx_prev`=1. `rx_s` lags `rx` by 2 edges.
- **Sample points** (defaults):
  - start bit: S+1+6 = S+7
  - data bit k (k = 0..7): S+7+14(k+1)
  - parity: S+133
  - stop: S+147
- **Completion:** `rx_complete`=1 for exactly the cycle following edge S+148; `rx_msg` and the flags update on that same edge.
- **Strobe width:** `rx_complete` is never high for 2 consecutive cycles.
- **Output stability:** outputs change only at a strobe or at reset.
- **Frame length:** 154 clocks per frame, matching `uart_tx` (11 × 14).
- **Clock tolerance:** sampling at count 6 of 14 tolerates about ±3 clocks of accumulated skew across the frame.

## Test plan
- **Even parity, 8'hA5:** `parity_type`=0; line bits in order 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, 14 clocks each -> one `rx_complete`, `rx_msg`=8'hA5, `parity_err`=0, `frame_err`=0, strobe at S+148.
- **Loopback:** `uart_tx` → `uart_rx`, 10 back-to-back bytes (00, FF, 55, AA, 01, 80, 3C, C3, 7E, E7), alternating `parity_type` per frame -> 10 strobes, each `rx_msg` equal to the `data` sent, all error flags 0.
- **Parity error:** byte 8'h0F sent with the parity bit inverted, `parity_type`=1 -> `rx_msg`=8'h0F, `parity_err`=1. The next good frame clears it to 0.
- **Framing error:** byte 8'h3C sent with the stop bit low for 14 clocks, then the line high -> `frame_err`=1, `rx_complete` pulses. A following good frame is received correctly.
- **Glitch / false start:** a 3-clock low pulse on an idle line -> no strobe, state back in IDLE. A valid frame starting 20 clocks later is received.
- **Reset:** `rst` pulsed for 1 cycle during data bit 4 -> all outputs 0 on the next edge, no strobe for that frame. A frame starting 30 clocks after reset is received correctly. `rx` held low through reset release -> no reception until `rx` has gone high and then low again.
